// File: rtl/iiitb_sd_ctrl.sv
// Byte-to-serial sequencer with a programmable overlapping pattern matcher and match counter.
// Optional saturating match counter is built only when SDC_MATCH_CNT_EN is defined.
module iiitb_sd_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             sd_din,
  output logic             sd_bvalid,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1010);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(4);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] hcnt_q, hcnt_d;
  logic             y_q, y_d;

  logic             xfer;
  logic             last_bit;
  logic             cfg_ld;
  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] hcnt_inc;
  logic [PAT_W-1:0] len_mask;
  logic             match;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      idx_q   <= '0;
      pat_q   <= PAT_RST;
      len_q   <= LEN_RST;
      hist_q  <= '0;
      hcnt_q  <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      y_q     <= y_d;
    end
  end

  assign last_bit = (state_q == S_SHIFT) && (idx_q == 3'd0);
  assign xfer     = in_valid && in_ready;
  assign cfg_ld   = (state_q == S_IDLE) && cfg_we;

  // Next-state logic; enable is only looked at once the current byte has fully left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (xfer)         state_d = S_SHIFT;
        else if (!enable) state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (last_bit) begin
          if (xfer)        state_d = S_SHIFT;
          else if (enable) state_d = S_WAIT;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    sd_bvalid = 1'b0;
    sd_din    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_WAIT: begin
        in_ready = 1'b1;
      end
      S_SHIFT: begin
        in_ready  = (idx_q == 3'd0);
        sd_bvalid = 1'b1;
        sd_din    = byte_q[idx_q];
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Byte holding register and bit index
  always_comb begin
    byte_d = byte_q;
    idx_d  = idx_q;
    if (xfer) begin
      byte_d = in_data;
      idx_d  = 3'd7;
    end else if (state_q == S_SHIFT) begin
      idx_d = idx_q - 3'd1;
    end
  end

  // Configuration: oversize lengths are clamped on load so the matcher never reads past hist.
  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    if (cfg_ld) begin
      pat_d = cfg_pat;
      len_d = len_clamped;
    end
  end

  // Matcher works on the history as it will look after the current bit is shifted in.
  assign hist_shift = {hist_q[PAT_W-2:0], sd_din};
  assign hcnt_inc   = (hcnt_q == LEN_MAX) ? hcnt_q : hcnt_q + LEN_W'(1);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign match = (len_q != '0) && (hcnt_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & len_mask) == '0);

  always_comb begin
    hist_d = hist_q;
    hcnt_d = hcnt_q;
    y_d    = 1'b0;
    if (cfg_ld) begin
      hist_d = '0;
      hcnt_d = '0;
    end else if (sd_bvalid) begin
      hist_d = hist_shift;
      hcnt_d = hcnt_inc;
      y_d    = match;
    end
  end

  assign y = y_q;

`ifdef SDC_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Counts on the same edge that raises y, so match_cnt and y change together.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_ld)                    cnt_d = '0;
    else if (y_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_iiitb_sd_ctrl.sv
// Bench for iiitb_sd_ctrl: byte table with per-bit expected match pulses, scoreboard-checked serial stream.
module tb_iiitb_sd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready, sd_din, sd_bvalid, y, busy;
  logic [7:0] match_cnt;
  logic       in_ready2, sd_din2, sd_bvalid2, y2, busy2;
  logic [1:0] match_cnt2;

`ifdef SDC_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  iiitb_sd_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sd_din(sd_din), .sd_bvalid(sd_bvalid), .y(y),
    .match_cnt(match_cnt), .busy(busy)
  );

  // Narrow-counter copy fed identical stimulus to exercise saturation.
  iiitb_sd_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .sd_din(sd_din2), .sd_bvalid(sd_bvalid2), .y(y2),
    .match_cnt(match_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic din;
    logic y;
  } sb_t;

  typedef struct {
    logic       cfg;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] data;
    logic [7:0] ymask;   // bit i = match pulse expected after the i-th presented bit
    int         cnt;     // unsaturated match count after the byte
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[7];
  int   checks = 0;
  int   failures = 0;
  logic exp_y = 1'b0;
  int   run_len = 0;
  int   max_run = 0;
  int   rdy_in_shift = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!CNT_EN) return 0;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic check_cnt(input int raw);
    check("match_cnt", {24'd0, match_cnt}, exp_cnt(raw, 8));
    check("match_cnt_w2", {30'd0, match_cnt2}, exp_cnt(raw, 2));
  endtask

  // Stream monitor: pops one expected bit per valid cycle; y is due one cycle later.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        exp_y   = 1'b0;
        run_len = 0;
      end else begin
        check("y", {31'd0, y}, {31'd0, exp_y});
        exp_y = 1'b0;
        if (sd_bvalid) begin
          check("busy_shift", {31'd0, busy}, 32'd1);
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (in_ready) rdy_in_shift++;
          check("bit_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sd_din", {31'd0, sd_din}, {31'd0, e.din});
            exp_y = e.y;
          end
        end else begin
          run_len = 0;
          check("busy_idle", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] ym);
    int  n;
    sb_t e;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    if (in_ready === 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        e.din = d[7-i];
        e.y   = ym[i];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || sd_bvalid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, (n < 60)}, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l);
    int n;
    n = 0;
    enable = 1'b0;
    while ((busy || in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, (busy | in_ready)}, 32'd0);
    cfg_we  = 1'b1;
    cfg_pat = p;
    cfg_len = l;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    enable = 1'b1;
    check_cnt(0);
  endtask

  task automatic run_vec(input int i);
    if (tbl[i].cfg) do_cfg(tbl[i].pat, tbl[i].len);
    send(tbl[i].data, tbl[i].ymask);
    drain();
    check_cnt(tbl[i].cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'h00, 4'd0,  8'hA0, 8'b0000_1000, 1};
    tbl[1] = '{1'b0, 8'h00, 4'd0,  8'hAA, 8'b1010_1000, 4};
    tbl[2] = '{1'b1, 8'hFF, 4'd8,  8'hFF, 8'b1000_0000, 1};
    tbl[3] = '{1'b0, 8'h00, 4'd0,  8'hFF, 8'b1111_1111, 9};
    tbl[4] = '{1'b1, 8'hFF, 4'd0,  8'hFF, 8'b0000_0000, 0};
    tbl[5] = '{1'b1, 8'hF5, 4'd3,  8'hA8, 8'b0001_0100, 2};
    tbl[6] = '{1'b1, 8'h0F, 4'd15, 8'h0F, 8'b1000_0000, 1};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_sd_din",    {31'd0, sd_din},    32'd0);
    check("rst_sd_bvalid", {31'd0, sd_bvalid}, 32'd0);
    check("rst_y",         {31'd0, y},         32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check_cnt(0);

    enable = 1'b1;
    @(posedge clk);
    #1;
    check("wait_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 2; i++) run_vec(i);

    // Back-to-back bytes with in_valid held: one unbroken 16-bit run.
    max_run      = 0;
    rdy_in_shift = 0;
    send(8'h55, 8'b0101_0000);
    send(8'h0F, 8'b0000_0001);
    drain();
    check("b2b_run_len", max_run, 16);
    check("b2b_ready_cycles", rdy_in_shift, 2);
    check_cnt(7);

    // Configuration write outside IDLE must leave pattern and count untouched.
    cfg_we  = 1'b1;
    cfg_pat = 8'hFF;
    cfg_len = 4'd8;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check_cnt(7);
    send(8'h0A, 8'b1000_0000);
    drain();
    check_cnt(8);

    // Reset in the middle of a byte: the remaining bits are dropped.
    send(8'hAA, 8'b1010_1010);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_bvalid", {31'd0, sd_bvalid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_bvalid",  {31'd0, sd_bvalid}, 32'd0);
    check("midrst_busy",    {31'd0, busy},      32'd0);
    check("midrst_inready", {31'd0, in_ready},  32'd0);
    check("midrst_y",       {31'd0, y},         32'd0);
    check_cnt(0);
    send(8'hA0, 8'b0000_1000);
    drain();
    check_cnt(1);

    for (int i = 2; i < 7; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
